// File: rtl/ntt_poly_mult_driver.sv
// ntt_poly_mult_driver
// Host-side initiator for the NTT polynomial multiplier. Streams A[0..N-1] then
// B[0..N-1] from a valid/ready input into the multiplier load port. It then holds
// mult_start while the multiplier runs, reads the N result coefficients back, and
// presents them on a valid/ready output stream.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_ready   input coefficient handshake, s_data coefficient in [0,Q)
//   m_valid/m_ready   output coefficient handshake, m_data result, m_last on N-1
//   busy              high while the FSM is out of idle
//   op_done           one-cycle pulse once the multiplier has released done
//   mult_load_*       load strobe/select(0=A,1=B)/address/data to the multiplier
//   mult_start        level start, held through the whole readback
//   mult_done         multiplier done (level), mult_busy multiplier busy
//   mult_read_addr    result read address (0 outside readback)
//   mult_read_data    result read data, valid READ_LATENCY cycles after the address
//
// Optional feature: define NTT_DRV_CENTER_EN to emit results as centered signed
// values (r > (Q-1)/2 ? r - Q : r) in WIDTH-bit two's complement.

module ntt_poly_mult_driver #(
  parameter int N            = 256,
  parameter int WIDTH        = 32,
  parameter int Q            = 8380417,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  op_done,
  output logic                  mult_load_coeff,
  output logic                  mult_load_sel,
  output logic [ADDR_WIDTH-1:0] mult_load_addr,
  output logic [WIDTH-1:0]      mult_load_data,
  output logic                  mult_start,
  input  logic                  mult_done,
  input  logic                  mult_busy,
  output logic [ADDR_WIDTH-1:0] mult_read_addr,
  input  logic [WIDTH-1:0]      mult_read_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT,
    S_RD_ADDR, S_RD_WAIT, S_OUT, S_RELEASE
  } state_t;

  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);
  localparam logic [1:0]       LAT_LAST = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [WIDTH-1:0] Q_W      = WIDTH'(Q);
  localparam logic [WIDTH-1:0] HALF_Q   = WIDTH'((Q - 1) / 2);
`ifdef NTT_DRV_CENTER_EN
  localparam bit CENTER_EN = 1'b1;
`else
  localparam bit CENTER_EN = 1'b0;
`endif

  state_t          state, next_state;
  logic [IW-1:0]   index;
  logic [1:0]      lat_cnt;
  logic            s_fire, m_fire, idx_last, capture;
  logic [WIDTH-1:0] result;

  // In idle, input is held off until the multiplier itself is idle again, which
  // also covers the case where this driver was reset mid-run.
  assign s_ready = (state == S_IDLE) ? (!mult_busy && !mult_done)
                                     : (state == S_LOAD_A || state == S_LOAD_B);
  assign s_fire   = s_valid && s_ready;
  assign m_fire   = m_valid && m_ready;
  assign idx_last = (index == LAST_IDX);

  // Start is decoded from the state register; S_START is a one-cycle spacer so
  // the start level never overlaps the final B load beat.
  assign mult_start = (state == S_WAIT) || (state == S_RD_ADDR) ||
                      (state == S_RD_WAIT) || (state == S_OUT);
  assign busy = (state != S_IDLE);
  assign mult_read_addr = (state == S_RD_ADDR || state == S_RD_WAIT) ?
                          index[ADDR_WIDTH-1:0] : '0;

  // Two's-complement wrap of r - Q gives the negative centered value directly.
  assign result = (CENTER_EN && (mult_read_data > HALF_Q)) ? (mult_read_data - Q_W)
                                                          : mult_read_data;

  // Read data is captured once the configured read latency has elapsed.
  always_comb begin
    capture = 1'b0;
    if (READ_LATENCY == 0) capture = (state == S_RD_ADDR);
    else                   capture = (state == S_RD_WAIT) && (lat_cnt == LAT_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:    if (s_fire) next_state = S_LOAD_A;
      S_LOAD_A:  if (s_fire && idx_last) next_state = S_LOAD_B;
      S_LOAD_B:  if (s_fire && idx_last) next_state = S_START;
      S_START:   next_state = S_WAIT;
      S_WAIT:    if (mult_done) next_state = S_RD_ADDR;
      S_RD_ADDR: next_state = (READ_LATENCY == 0) ? S_OUT : S_RD_WAIT;
      S_RD_WAIT: if (lat_cnt == LAT_LAST) next_state = S_OUT;
      S_OUT:     if (m_fire) next_state = m_last ? S_RELEASE : S_RD_ADDR;
      S_RELEASE: if (!mult_done) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Datapath: load beats, index/latency counters, output register, op_done.
  // The idle handshake is beat A[0], so the load index resumes at 1 in S_LOAD_A;
  // the index is back at 0 whenever a load phase or the readback completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      index           <= '0;
      lat_cnt         <= '0;
      mult_load_coeff <= 1'b0;
      mult_load_sel   <= 1'b0;
      mult_load_addr  <= '0;
      mult_load_data  <= '0;
      m_valid         <= 1'b0;
      m_data          <= '0;
      m_last          <= 1'b0;
      op_done         <= 1'b0;
    end else begin
      mult_load_coeff <= 1'b0;
      op_done         <= (state == S_RELEASE) && !mult_done;

      if (s_fire) begin
        mult_load_coeff <= 1'b1;
        mult_load_sel   <= (state == S_LOAD_B);
        mult_load_addr  <= (state == S_IDLE) ? '0 : index[ADDR_WIDTH-1:0];
        mult_load_data  <= s_data;
      end

      if (state == S_IDLE)
        index <= s_fire ? IW'(1) : '0;
      else if ((state == S_LOAD_A || state == S_LOAD_B) && s_fire)
        index <= idx_last ? '0 : index + 1'b1;
      else if (state == S_OUT && m_fire)
        index <= m_last ? '0 : index + 1'b1;

      lat_cnt <= (state == S_RD_WAIT) ? lat_cnt + 1'b1 : '0;

      if (capture) begin
        m_valid <= 1'b1;
        m_data  <= result;
        m_last  <= idx_last;
      end else if (m_fire) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule
